// File: rtl/mem_responder.sv
// mem_responder: memory-side responder shared by the fetch (IF) and load/store (MEM) initiators.
// Owns a unified byte-addressed array and serves one request at a time over a req/gnt/rvalid
// handshake. Each access waits LATENCY cycles between grant and response.
//
// Parameters: AW (byte-address width), DEPTH (array bytes, addresses wrap), LATENCY (0..15).
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch request; if_addr bit 0 ignored
//   if_gnt/if_rvalid/if_rdata fetch grant, response pulse, little-endian word
//   d_req/d_we/d_size/d_signed/d_addr/d_wdata  data request fields
//   d_gnt/d_rvalid/d_rdata/d_err               data grant, response pulse, load data, misalign error
//   busy                     high whenever the FSM is not idle
// Optional feature: define MEM_RESP_MISALIGN_CHK_EN to turn misaligned data half/word accesses
// into error responses (no array write, d_err=1, d_rdata=0). Undefined: d_err is always 0 and
// misaligned accesses are done bytewise with wrap.
module mem_responder #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic          d_signed,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [3:0] LatM1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_e        state;
  logic [3:0]    wait_cnt;
  logic [7:0]    mem [DEPTH];

  // Captured request fields
  logic          fetch_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [31:0]   wdata_q;

  // Fields of the access in flight; in IDLE these are the incoming granted fields so a
  // zero-latency response can be formed on the granting edge.
  logic          cur_fetch;
  logic [AW-1:0] cur_addr;
  logic          cur_we;
  logic [1:0]    cur_size;
  logic          cur_signed;
  logic          cur_mis;
  logic [31:0]   rd_word;
  logic [31:0]   load_data;
  logic [31:0]   d_resp;
  int unsigned   nbytes;
  logic          unused_if_addr_lsb;

  assign unused_if_addr_lsb = if_addr[0];

  function automatic logic [AW-1:0] byte_idx(input logic [AW-1:0] a, input int unsigned i);
    int unsigned s;
    s = (32'(a) + i) % DEPTH;
    return s[AW-1:0];
  endfunction

  // Data wins over fetch when both request in the same idle cycle.
  assign d_gnt  = d_req & (state == StIdle);
  assign if_gnt = if_req & ~d_req & (state == StIdle);
  assign busy   = (state != StIdle);

  always_comb begin
    if (state == StIdle) begin
      cur_fetch  = ~d_req;
      cur_addr   = d_req ? d_addr : {if_addr[AW-1:1], 1'b0};
      cur_we     = d_req & d_we;
      cur_size   = d_size;
      cur_signed = d_signed;
    end else begin
      cur_fetch  = fetch_q;
      cur_addr   = addr_q;
      cur_we     = we_q;
      cur_size   = size_q;
      cur_signed = signed_q;
    end
  end

`ifdef MEM_RESP_MISALIGN_CHK_EN
  assign cur_mis = ~cur_fetch & (((cur_size == 2'b01) & cur_addr[0]) |
                                 (cur_size[1] & (cur_addr[1:0] != 2'b00)));
`else
  assign cur_mis = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++) begin
      rd_word[8*i +: 8] = mem[byte_idx(cur_addr, i)];
    end
  end

  always_comb begin
    case (cur_size)
      2'b00:   load_data = {{24{cur_signed & rd_word[7]}}, rd_word[7:0]};
      2'b01:   load_data = {{16{cur_signed & rd_word[15]}}, rd_word[15:0]};
      default: load_data = rd_word;
    endcase
    d_resp = (cur_we | cur_mis) ? 32'd0 : load_data;
  end

  always_comb begin
    case (size_q)
      2'b00:   nbytes = 1;
      2'b01:   nbytes = 2;
      default: nbytes = 4;
    endcase
  end

  // Array has no reset; a reset forces the FSM to IDLE so an abandoned store never lands.
  always_ff @(posedge clk) begin
    if (state == StResp && we_q && !fetch_q && !cur_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (i < nbytes) mem[byte_idx(addr_q, i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      wait_cnt  <= 4'd0;
      fetch_q   <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      wdata_q   <= 32'd0;
      if_rvalid <= 1'b0;
      if_rdata  <= 32'd0;
      d_rvalid  <= 1'b0;
      d_rdata   <= 32'd0;
      d_err     <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      if_rdata  <= 32'd0;
      d_rvalid  <= 1'b0;
      d_rdata   <= 32'd0;
      d_err     <= 1'b0;
      unique case (state)
        StIdle: begin
          if (d_gnt || if_gnt) begin
            fetch_q  <= cur_fetch;
            addr_q   <= cur_addr;
            we_q     <= cur_we;
            size_q   <= d_size;
            signed_q <= d_signed;
            wdata_q  <= d_wdata;
            wait_cnt <= 4'd0;
            if (LATENCY == 0) begin
              state     <= StResp;
              if_rvalid <= cur_fetch;
              if_rdata  <= cur_fetch ? rd_word : 32'd0;
              d_rvalid  <= ~cur_fetch;
              d_rdata   <= cur_fetch ? 32'd0 : d_resp;
              d_err     <= cur_mis;
            end else begin
              state <= StWait;
            end
          end
        end
        StWait: begin
          if (wait_cnt == LatM1) begin
            state     <= StResp;
            if_rvalid <= cur_fetch;
            if_rdata  <= cur_fetch ? rd_word : 32'd0;
            d_rvalid  <= ~cur_fetch;
            d_rdata   <= cur_fetch ? 32'd0 : d_resp;
            d_err     <= cur_mis;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        StResp: begin
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a byte-array model produces expected responses that are
// queued at grant time and compared when the matching rvalid pulse appears.
module tb_mem_responder;
  localparam int unsigned AW      = 8;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 1;
`ifdef MEM_RESP_MISALIGN_CHK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0, d_signed = 1'b0;
  logic [1:0]    d_size = 2'b00;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic          d_gnt, d_rvalid, d_err, busy;
  logic [31:0]   d_rdata;

  mem_responder #(.AW(AW), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fetch;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mdl [DEPTH];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [AW-1:0] midx(input logic [AW-1:0] a, input int i);
    int unsigned s;
    s = (32'(a) + 32'(i)) % DEPTH;
    return s[AW-1:0];
  endfunction

  // Expected response of an access; stores update the model immediately.
  function automatic exp_t expect_for(input bit fetch, input bit we, input logic [1:0] size,
                                      input bit sgn, input logic [AW-1:0] addr,
                                      input logic [31:0] wdata);
    exp_t          e;
    logic [31:0]   w;
    logic [AW-1:0] base;
    bit            mis;
    int            nb;
    base = fetch ? {addr[AW-1:1], 1'b0} : addr;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mdl[midx(base, i)];
    mis = ChkEn && !fetch && ((size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00));
    e.fetch = fetch;
    e.err   = mis;
    e.data  = 32'd0;
    if (fetch) begin
      e.data = w;
    end else if (!mis && we) begin
      nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      for (int i = 0; i < nb; i++) mdl[midx(addr, i)] = wdata[8*i +: 8];
    end else if (!mis) begin
      case (size)
        2'b00:   e.data = {{24{sgn & w[7]}}, w[7:0]};
        2'b01:   e.data = {{16{sgn & w[15]}}, w[15:0]};
        default: e.data = w;
      endcase
    end
    return e;
  endfunction

  task automatic wait_resp(input bit chk_lat);
    int   k;
    bit   seen;
    exp_t e;
    k = 0;
    seen = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (chk_lat) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL busy_during_access: busy=%b at cycle %0d, required 1", busy, k);
        end
      end
      if (if_rvalid === 1'b1 || d_rvalid === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen || sb.size() == 0) begin
      n_bad++;
      $display("FAIL rvalid_timeout: seen=%0d queued=%0d, required a response", seen, sb.size());
      return;
    end
    e = sb.pop_front();
    if (chk_lat) begin
      n_cmp++;
      if (k != int'(LATENCY) + 1) begin
        n_bad++;
        $display("FAIL latency: rvalid %0d cycles after gnt, required %0d", k, LATENCY + 1);
      end
    end
    n_cmp++;
    if (e.fetch ? (if_rvalid !== 1'b1 || d_rvalid !== 1'b0)
                : (d_rvalid !== 1'b1 || if_rvalid !== 1'b0)) begin
      n_bad++;
      $display("FAIL rvalid_port: if_rvalid=%b d_rvalid=%b, required fetch=%b", if_rvalid,
               d_rvalid, e.fetch);
    end
    n_cmp++;
    if ((e.fetch ? if_rdata : d_rdata) !== e.data) begin
      n_bad++;
      $display("FAIL rdata: got %h, required %h", e.fetch ? if_rdata : d_rdata, e.data);
    end
    if (!e.fetch) begin
      n_cmp++;
      if (d_err !== e.err) begin
        n_bad++;
        $display("FAIL d_err: got %b, required %b", d_err, e.err);
      end
    end
    if (chk_lat) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
        n_bad++;
        $display("FAIL after_resp: busy=%b if_rvalid=%b d_rvalid=%b, required 0 0 0", busy,
                 if_rvalid, d_rvalid);
      end
    end
  endtask

  task automatic access(input bit fetch, input bit we, input logic [1:0] size, input bit sgn,
                        input logic [AW-1:0] addr, input logic [31:0] wdata, input bit chk_lat);
    int cyc;
    @(negedge clk);
    if (fetch) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_size = size; d_signed = sgn; d_addr = addr; d_wdata = wdata;
    end
    #1;
    cyc = 0;
    while (!(fetch ? if_gnt : d_gnt) && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    n_cmp++;
    if (cyc >= 20) begin
      n_bad++;
      $display("FAIL gnt_timeout: no grant in 20 cycles, required a grant");
      if_req = 1'b0; d_req = 1'b0;
      return;
    end
    sb.push_back(expect_for(fetch, we, size, sgn, addr, wdata));
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    d_wdata = 32'h0BAD_0BAD;  // fields may change after grant
    wait_resp(chk_lat);
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (busy !== 1'b0 || d_gnt !== 1'b0 || if_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: busy=%b d_gnt=%b if_gnt=%b, required 0 0 0", busy, d_gnt, if_gnt);
    end
    n_cmp++;
    if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || d_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid: if_rvalid=%b d_rvalid=%b d_err=%b, required 0 0 0", if_rvalid,
               d_rvalid, d_err);
    end
    n_cmp++;
    if (if_rdata !== 32'd0 || d_rdata !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_rdata: if_rdata=%h d_rdata=%h, required 0 0", if_rdata, d_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_word();
    access(1'b0, 1'b1, 2'b10, 1'b0, 8'h10, 32'hDEAD_BEEF, 1'b1);
    access(1'b0, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 1'b1);
  endtask

  task automatic test_byte_half();
    access(1'b0, 1'b1, 2'b00, 1'b0, 8'h21, 32'h1234_5680, 1'b0);
    access(1'b0, 1'b0, 2'b00, 1'b1, 8'h21, 32'h0, 1'b0);
    access(1'b0, 1'b0, 2'b00, 1'b0, 8'h21, 32'h0, 1'b0);
    access(1'b0, 1'b1, 2'b01, 1'b0, 8'h20, 32'hABCD_8001, 1'b0);
    access(1'b0, 1'b0, 2'b01, 1'b1, 8'h20, 32'h0, 1'b0);
    access(1'b0, 1'b0, 2'b01, 1'b0, 8'h20, 32'h0, 1'b0);
  endtask

  task automatic test_fetch();
    access(1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 32'h1111_2222, 1'b0);
    access(1'b0, 1'b1, 2'b10, 1'b0, 8'h04, 32'h3333_4444, 1'b0);
    access(1'b1, 1'b0, 2'b00, 1'b0, 8'h02, 32'h0, 1'b1);
    access(1'b1, 1'b0, 2'b00, 1'b0, 8'h03, 32'h0, 1'b0);
  endtask

  task automatic test_arb();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_signed = 1'b0; d_addr = 8'h10;
    if_req = 1'b1; if_addr = 8'h04;
    #1;
    n_cmp++;
    if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL arb_grant: d_gnt=%b if_gnt=%b, required 1 0", d_gnt, if_gnt);
    end
    sb.push_back(expect_for(1'b0, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0));
    @(posedge clk); #1;
    d_req = 1'b0;
    wait_resp(1'b0);
    @(negedge clk); #1;
    n_cmp++;
    if (if_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL arb_fetch_gnt: if_gnt=%b in first idle cycle, required 1", if_gnt);
      if_req = 1'b0;
      return;
    end
    sb.push_back(expect_for(1'b1, 1'b0, 2'b00, 1'b0, 8'h04, 32'h0));
    @(posedge clk); #1;
    if_req = 1'b0;
    wait_resp(1'b1);
  endtask

  task automatic test_wrap();
    access(1'b0, 1'b1, 2'b10, 1'b0, 8'hFC, 32'h0000_0000, 1'b0);
    access(1'b0, 1'b1, 2'b10, 1'b0, 8'hFE, 32'hA1B2_C3D4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 1'b0, 2'b00, 1'b0, midx(8'hFE, i), 32'h0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    bit any;
    access(1'b0, 1'b1, 2'b10, 1'b0, 8'h30, 32'h1234_5678, 1'b0);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 8'h30; d_wdata = 32'h5555_5555;
    #1;
    n_cmp++;
    if (d_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_gnt: d_gnt=%b, required 1", d_gnt);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || d_rvalid !== 1'b0 || d_rdata !== 32'd0) begin
      n_bad++;
      $display("FAIL rstmid_state: busy=%b d_rvalid=%b d_rdata=%h, required 0 0 0", busy,
               d_rvalid, d_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    any = 0;
    repeat (4) begin
      @(negedge clk);
      if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) any = 1;
    end
    n_cmp++;
    if (any) begin
      n_bad++;
      $display("FAIL rstmid_rvalid: rvalid seen after reset, required none");
    end
    access(1'b0, 1'b0, 2'b10, 1'b0, 8'h30, 32'h0, 1'b0);
  endtask

  task automatic test_misalign();
    access(1'b0, 1'b1, 2'b10, 1'b0, 8'h34, 32'h9ABC_DEF0, 1'b0);
    access(1'b0, 1'b1, 2'b10, 1'b0, 8'h31, 32'hCAFE_F00D, 1'b0);
    for (int i = 0; i < 6; i++) begin
      access(1'b0, 1'b0, 2'b00, 1'b0, 8'(8'h30 + i), 32'h0, 1'b0);
    end
    access(1'b0, 1'b0, 2'b10, 1'b0, 8'h31, 32'h0, 1'b0);
    access(1'b0, 1'b0, 2'b01, 1'b1, 8'h33, 32'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_fetch();
    test_arb();
    test_wrap();
    test_reset_mid();
    test_misalign();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
